// File: rtl/calc1_port_driver.sv
// calc1_port_driver: buffers complete calc1 operations in a small FIFO, issues
// each one onto the calc1 port (cmd+op1, then op2), waits for the port response
// or a timeout, and hands the result downstream over a valid/ready interface.
// Only one operation is ever in flight on the port.
module calc1_port_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  // Request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_op1,
  input  logic [0:31] req_op2,
  // calc1 port side
  output logic [0:3]  calc_cmd_out,
  output logic [0:31] calc_data_out,
  input  logic [0:1]  calc_resp_in,
  input  logic [0:31] calc_data_in,
  // Response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:3]  rsp_cmd,
  output logic [0:1]  rsp_code,
  output logic [0:31] rsp_data,
  // Status
  output logic        busy,
  output logic        timeout_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [0:1]    CODE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_OP1,
    S_SEND_OP2,
    S_WAIT_RESP,
    S_HOLD
  } state_t;

  // Request FIFO storage and bookkeeping
  logic [0:3]    fifoCmd [FIFO_DEPTH];
  logic [0:31]   fifoOp1 [FIFO_DEPTH];
  logic [0:31]   fifoOp2 [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Controller state, working copy of the active operation, registered outputs
  state_t        state_q, state_d;
  logic [0:3]    workCmd_q, workCmd_d;
  logic [0:31]   workOp2_q, workOp2_d;
  logic [7:0]    timer_q, timer_d;
  logic [0:3]    calcCmd_q, calcCmd_d;
  logic [0:31]   calcData_q, calcData_d;
  logic          rspValid_q, rspValid_d;
  logic [0:3]    rspCmd_q, rspCmd_d;
  logic [0:1]    rspCode_q, rspCode_d;
  logic [0:31]   rspData_q, rspData_d;
  logic          timeoutErr_q, timeoutErr_d;

  assign req_ready = (count_q != DEPTH_C);
  assign push      = req_valid & req_ready;

  // FIFO payload storage; contents need no reset because count gates every read
  always_ff @(posedge c_clk) begin
    if (push) begin
      fifoCmd[wrPtr_q] <= req_cmd;
      fifoOp1[wrPtr_q] <= req_op1;
      fifoOp2[wrPtr_q] <= req_op2;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Next-state and output decode; the calc port values are computed for the
  // state being entered so the registered outputs line up with that state
  always_comb begin
    state_d      = state_q;
    workCmd_d    = workCmd_q;
    workOp2_d    = workOp2_q;
    timer_d      = timer_q;
    calcCmd_d    = '0;
    calcData_d   = '0;
    rspValid_d   = rspValid_q;
    rspCmd_d     = rspCmd_q;
    rspCode_d    = rspCode_q;
    rspData_d    = rspData_q;
    timeoutErr_d = timeoutErr_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          workCmd_d  = fifoCmd[rdPtr_q];
          workOp2_d  = fifoOp2[rdPtr_q];
          calcCmd_d  = fifoCmd[rdPtr_q];
          calcData_d = fifoOp1[rdPtr_q];
          state_d    = S_SEND_OP1;
        end
      end

      S_SEND_OP1: begin
        calcCmd_d  = '0;
        calcData_d = workOp2_q;
        state_d    = S_SEND_OP2;
      end

      S_SEND_OP2: begin
        timer_d = '0;
        state_d = S_WAIT_RESP;
      end

      S_WAIT_RESP: begin
        timer_d = timer_q + 8'd1;
        if (calc_resp_in != 2'd0) begin
          rspValid_d = 1'b1;
          rspCmd_d   = workCmd_q;
          rspCode_d  = calc_resp_in;
          rspData_d  = calc_data_in;
          state_d    = S_HOLD;
        end else if (timer_q == TIMER_LAST) begin
          rspValid_d   = 1'b1;
          rspCmd_d     = workCmd_q;
          rspCode_d    = CODE_TIMEOUT;
          rspData_d    = '0;
          timeoutErr_d = 1'b1;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state, working registers and all registered outputs
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      workCmd_q    <= '0;
      workOp2_q    <= '0;
      timer_q      <= '0;
      calcCmd_q    <= '0;
      calcData_q   <= '0;
      rspValid_q   <= 1'b0;
      rspCmd_q     <= '0;
      rspCode_q    <= '0;
      rspData_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      workCmd_q    <= workCmd_d;
      workOp2_q    <= workOp2_d;
      timer_q      <= timer_d;
      calcCmd_q    <= calcCmd_d;
      calcData_q   <= calcData_d;
      rspValid_q   <= rspValid_d;
      rspCmd_q     <= rspCmd_d;
      rspCode_q    <= rspCode_d;
      rspData_q    <= rspData_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign calc_cmd_out  = calcCmd_q;
  assign calc_data_out = calcData_q;
  assign rsp_valid     = rspValid_q;
  assign rsp_cmd       = rspCmd_q;
  assign rsp_code      = rspCode_q;
  assign rsp_data      = rspData_q;
  assign timeout_err   = timeoutErr_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed testbench for calc1_port_driver with a small behavioural calc1 port.
module tb_calc1_port_driver;

  localparam int TIMEOUT = 64;

  logic        c_clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [0:3]  req_cmd;
  logic [0:31] req_op1;
  logic [0:31] req_op2;
  logic [0:3]  calc_cmd_out;
  logic [0:31] calc_data_out;
  logic [0:1]  calc_resp_in;
  logic [0:31] calc_data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:3]  rsp_cmd;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Behavioural calc1 port controls
  bit          modelEnable  = 1'b1;
  int          modelDelay   = 1;
  bit          overrideEn   = 1'b0;
  logic [0:1]  overrideResp = '0;
  logic [0:31] overrideData = '0;
  bit          strayEn      = 1'b0;
  int          mPhase;
  int          mCnt;
  logic [0:3]  mCmd;
  logic [0:31] mOp1;
  logic [0:31] mOp2;

  calc1_port_driver #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .calc_cmd_out (calc_cmd_out),
    .calc_data_out(calc_data_out),
    .calc_resp_in (calc_resp_in),
    .calc_data_in (calc_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_cmd      (rsp_cmd),
    .rsp_code     (rsp_code),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // Free-running clock
  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  // calc1 port model: watches the driver outputs on the falling edge and
  // answers with a one-cycle response pulse modelDelay cycles after op2
  initial begin
    calc_resp_in = '0;
    calc_data_in = '0;
    mPhase = 0;
    mCnt   = 0;
    mCmd   = '0;
    mOp1   = '0;
    mOp2   = '0;
    forever begin
      @(negedge c_clk);
      calc_resp_in = '0;
      calc_data_in = '0;
      if (reset) begin
        mPhase = 0;
        mCnt   = 0;
      end else if (calc_cmd_out != 4'd0) begin
        mCmd   = calc_cmd_out;
        mOp1   = calc_data_out;
        mPhase = 1;
      end else if (mPhase == 1) begin
        mOp2   = calc_data_out;
        mPhase = 2;
        mCnt   = 0;
      end else if (mPhase == 2) begin
        mCnt++;
        if (modelEnable && mCnt >= modelDelay) begin
          if (overrideEn) begin
            calc_resp_in = overrideResp;
            calc_data_in = overrideData;
          end else begin
            case (mCmd)
              4'd1: begin calc_resp_in = 2'd1; calc_data_in = mOp1 + mOp2; end
              4'd2: begin calc_resp_in = 2'd1; calc_data_in = mOp1 - mOp2; end
              default: begin calc_resp_in = 2'd2; calc_data_in = '0; end
            endcase
          end
          mPhase = 0;
        end
      end else if (strayEn) begin
        calc_resp_in = 2'd1;
        calc_data_in = 32'h1234_5678;
      end
    end
  end

  // Offer one request at a falling edge and hold it until accepted
  task automatic pushReq(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b);
    int n = 0;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge c_clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
    end else begin
      @(negedge c_clk);
      req_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for a response to be presented
  task automatic waitRsp(input string tag, input int bound);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < bound) begin
      @(negedge c_clk);
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_wait: rsp_valid=%b after %0d cycles, required 1", tag, rsp_valid, n);
    end
  endtask

  // Complete one response handshake
  task automatic acceptRsp();
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    rsp_ready = 1'b0;
    #3 reset = 1'b1;
    @(negedge c_clk);
    @(negedge c_clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctl: ready=%b busy=%b valid=%b terr=%b, required 1 0 0 0",
               req_ready, busy, rsp_valid, timeout_err);
    end
    checks++;
    if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd0 || rsp_cmd !== 4'd0 ||
        rsp_code !== 2'd0 || rsp_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: ccmd=%0d cdata=%h rcmd=%0d rcode=%0d rdata=%h, required all 0",
               calc_cmd_out, calc_data_out, rsp_cmd, rsp_code, rsp_data);
    end
    reset = 1'b0;
    @(negedge c_clk);
  endtask

  task automatic test_single_add();
    modelDelay = 3;
    pushReq(4'd1, 32'd5, 32'd7);
    checks++;
    if (calc_cmd_out !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_push: ccmd=%0d busy=%b, required 0 1", calc_cmd_out, busy);
    end
    @(negedge c_clk);
    checks++;
    if (calc_cmd_out !== 4'd1 || calc_data_out !== 32'd5) begin
      errors++;
      $display("[TB] FAIL add_op1: cmd=%0d data=%0d, required 1 5", calc_cmd_out, calc_data_out);
    end
    @(negedge c_clk);
    checks++;
    if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd7) begin
      errors++;
      $display("[TB] FAIL add_op2: cmd=%0d data=%0d, required 0 7", calc_cmd_out, calc_data_out);
    end
    @(negedge c_clk);
    checks++;
    if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd0) begin
      errors++;
      $display("[TB] FAIL add_wait_out: cmd=%0d data=%0d, required 0 0", calc_cmd_out, calc_data_out);
    end
    @(negedge c_clk);
    @(negedge c_clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_early: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge c_clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_cmd !== 4'd1 || rsp_code !== 2'd1 || rsp_data !== 32'd12) begin
      errors++;
      $display("[TB] FAIL add_rsp: valid=%b cmd=%0d code=%0d data=%0d, required 1 1 1 12",
               rsp_valid, rsp_cmd, rsp_code, rsp_data);
    end
    checks++;
    if (mOp1 !== 32'd5 || mOp2 !== 32'd7) begin
      errors++;
      $display("[TB] FAIL add_port_seen: op1=%0d op2=%0d, required 5 7", mOp1, mOp2);
    end
    acceptRsp();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_done: valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    modelDelay = 1;
  endtask

  task automatic test_walking_ones();
    logic [0:31] x;
    for (int k = 0; k <= 30; k++) begin
      x = 32'd1 << k;
      pushReq(4'd1, x, 32'd0);
      waitRsp("walk", 50);
      checks++;
      if (rsp_data !== x || rsp_code !== 2'd1 || rsp_cmd !== 4'd1) begin
        errors++;
        $display("[TB] FAIL walk_%0d: data=%h code=%0d cmd=%0d, required %h 1 1",
                 k, rsp_data, rsp_code, rsp_cmd, x);
      end
      acceptRsp();
    end
  endtask

  task automatic test_fill_fifo();
    logic [0:31] fillExp [6];
    int n;
    fillExp[0] = 32'd101;
    fillExp[1] = 32'd10;
    fillExp[2] = 32'd21;
    fillExp[3] = 32'd32;
    fillExp[4] = 32'd43;
    fillExp[5] = 32'd54;
    pushReq(4'd1, 32'd100, 32'd1);
    waitRsp("fill_stall", 50);
    for (int i = 0; i < 4; i++) begin
      pushReq(4'd1, 32'((i + 1) * 10), 32'(i));
    end
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_full: ready=%b busy=%b, required 0 1", req_ready, busy);
    end
    req_cmd   = 4'd1;
    req_op1   = 32'd50;
    req_op2   = 32'd4;
    req_valid = 1'b1;
    @(negedge c_clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_blocked: ready=%b, required 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== fillExp[0]) begin
      errors++;
      $display("[TB] FAIL fill_rsp0: valid=%b data=%0d, required 1 %0d", rsp_valid, rsp_data, fillExp[0]);
    end
    acceptRsp();
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge c_clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_fifth: ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(negedge c_clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      waitRsp("fill", 50);
      checks++;
      if (rsp_data !== fillExp[i] || rsp_code !== 2'd1) begin
        errors++;
        $display("[TB] FAIL fill_rsp%0d: data=%0d code=%0d, required %0d 1",
                 i, rsp_data, rsp_code, fillExp[i]);
      end
      acceptRsp();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_drained: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    overrideEn   = 1'b1;
    overrideResp = 2'd2;
    overrideData = 32'hFFFF_FFFF;
    modelDelay   = 2;
    pushReq(4'd2, 32'd0, 32'd1);
    waitRsp("bp", 50);
    strayEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge c_clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_code !== 2'd2 || rsp_data !== 32'hFFFF_FFFF || rsp_cmd !== 4'd2) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b code=%0d data=%h cmd=%0d, required 1 2 ffffffff 2",
                 i, rsp_valid, rsp_code, rsp_data, rsp_cmd);
      end
    end
    overrideEn = 1'b0;
    acceptRsp();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_after_%0d: valid=%b busy=%b, required 0 0", i, rsp_valid, busy);
      end
      @(negedge c_clk);
    end
    strayEn    = 1'b0;
    modelDelay = 1;
  endtask

  task automatic test_timeout_race();
    int n = 0;
    modelDelay = TIMEOUT;
    pushReq(4'd1, 32'd20, 32'd22);
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge c_clk);
      n++;
    end
    checks++;
    if (n != 67 || rsp_code !== 2'd1 || rsp_data !== 32'd42 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL race: cycles=%0d code=%0d data=%0d terr=%b, required 67 1 42 0",
               n, rsp_code, rsp_data, timeout_err);
    end
    acceptRsp();
    modelDelay = 1;
  endtask

  task automatic test_timeout();
    int n = 0;
    modelEnable = 1'b0;
    pushReq(4'd1, 32'd3, 32'd4);
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge c_clk);
      n++;
    end
    checks++;
    if (n != 67) begin
      errors++;
      $display("[TB] FAIL to_latency: cycles=%0d, required 67", n);
    end
    checks++;
    if (rsp_code !== 2'd3 || rsp_data !== 32'd0 || rsp_cmd !== 4'd1 || timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_rsp: code=%0d data=%h cmd=%0d terr=%b, required 3 0 1 1",
               rsp_code, rsp_data, rsp_cmd, timeout_err);
    end
    acceptRsp();
    modelEnable = 1'b1;
    pushReq(4'd1, 32'd8, 32'd9);
    waitRsp("to_next", 50);
    checks++;
    if (rsp_code !== 2'd1 || rsp_data !== 32'd17 || timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_sticky: code=%0d data=%0d terr=%b, required 1 17 1",
               rsp_code, rsp_data, timeout_err);
    end
    acceptRsp();
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    modelEnable = 1'b0;
    pushReq(4'd1, 32'd1, 32'd1);
    pushReq(4'd1, 32'd2, 32'd2);
    pushReq(4'd1, 32'd3, 32'd3);
    for (int i = 0; i < 4; i++) @(negedge c_clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_pre: busy=%b valid=%b, required 1 0", busy, rsp_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd0 || rsp_valid !== 1'b0 ||
        busy !== 1'b0 || req_ready !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: ccmd=%0d cdata=%h valid=%b busy=%b ready=%b terr=%b, required 0 0 0 0 1 0",
               calc_cmd_out, calc_data_out, rsp_valid, busy, req_ready, timeout_err);
    end
    @(negedge c_clk);
    @(negedge c_clk);
    reset = 1'b0;
    modelEnable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge c_clk);
      if (rsp_valid !== 1'b0 || calc_cmd_out !== 4'd0) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_after: active_cycles=%0d busy=%b, required 0 0", seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_walking_ones();
    test_fill_fifo();
    test_backpressure();
    test_timeout_race();
    test_timeout();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc1_port_driver.md
# calc1_port_driver

Upstream request driver for one calc1 port. Accepts complete operations (command plus two operands) over a valid/ready interface, buffers them in a small FIFO, and serialises each onto the calc1 port protocol: command with operand 1, then operand 2. It then waits for the port response, or times out, and returns the result over a second valid/ready interface. Only one operation is outstanding on the port at a time.

## Interface
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2
- TIMEOUT, 64, WAIT_RESP cycles before a synthesised timeout response; at least 2, at most 255
- c_clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears FIFO, FSM, all outputs
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_cmd  in  [0:3]  calc1 command (1 add, 2 sub, 5 shl, 6 shr)
- req_op1  in  [0:31]  operand 1
- req_op2  in  [0:31]  operand 2
- calc_cmd_out  out  [0:3]  to calc1 port cmd_in
- calc_data_out  out  [0:31]  to calc1 port data_in
- calc_resp_in  in  [0:1]  from calc1 port out_resp
- calc_data_in  in  [0:31]  from calc1 port out_data
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer accepts result
- rsp_cmd  out  [0:3]  command of completed operation
- rsp_code  out  [0:1]  1 success, 2 overflow/underflow/invalid, 3 timeout
- rsp_data  out  [0:31]  result word (0 when code 3)
- busy  out  1  FSM not IDLE or FIFO non-empty
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- FIFO: push when req_valid & req_ready; req_ready = (count != FIFO_DEPTH), combinational from registered count. Same-cycle push and pop leaves count unchanged. Order is strictly FIFO.
- Commands are forwarded unmodified. Invalid codes go to calc1, which returns code 2.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the working registers and go to SEND_OP1.
  - SEND_OP1: calc_cmd_out = cmd, calc_data_out = op1 for exactly one cycle; go to SEND_OP2.
  - SEND_OP2: calc_cmd_out = 0, calc_data_out = op2 for one cycle; clear the timer; go to WAIT_RESP.
  - WAIT_RESP: cmd/data outputs 0; timer increments each cycle.
    - If calc_resp_in != 0: capture calc_resp_in and calc_data_in into rsp_code and rsp_data, set rsp_valid, go to HOLD.
    - Else if timer reaches TIMEOUT-1: rsp_code = 3, rsp_data = 0, set timeout_err and rsp_valid, go to HOLD.
  - HOLD: rsp_* stable while rsp_valid & !rsp_ready; on rsp_ready, clear rsp_valid and go to IDLE.
- calc_resp_in in any state other than WAIT_RESP is ignored.
- A real response in the same cycle the timer expires wins; it is captured with its own code.
- Reset mid-operation: FIFO emptied, FSM to IDLE, calc outputs 0 on assertion (async). The calc1 port must be reset alongside.

## Timing
- Reset values: req_ready 1, calc_cmd_out 0, calc_data_out 0, rsp_valid 0, rsp_cmd 0, rsp_code 0, rsp_data 0, busy 0, timeout_err 0.
- All outputs are registered except req_ready and busy (decoded from registered state).
- Push at edge N with the FIFO empty and FSM in IDLE: pop at N+1, SEND_OP1 outputs valid during cycle N+1..N+2, SEND_OP2 during N+2..N+3.
- Response sampled at edge E in WAIT_RESP: rsp_valid high from E.
- Minimum back-to-back spacing: SEND_OP1 of the next operation starts the cycle after rsp_ready is accepted in HOLD.
- Timeout: rsp_valid rises TIMEOUT cycles after entering WAIT_RESP.

## Test plan
- Single add, cmd 1, op1 5, op2 7; model responds resp 1, data 12 after 3 cycles -> calc_cmd_out=1/data=5 for one cycle, then 0/7 for one cycle; rsp_valid with cmd 1, code 1, data 12.
- Walking-one adds, x = 1<<k for k = 0..30, op2 0 -> each rsp_data == x, code 1, in order.
- Fill FIFO: push 5 requests with FSM stalled (rsp_ready 0) -> req_ready low after 4 accepted; 5th accepted after a pop; all 5 responses in order.
- Timeout: model never responds -> after 64 WAIT_RESP cycles, code 3, data 0, timeout_err 1, which stays 1 for later successes.
- Backpressure: hold rsp_ready 0 for 10 cycles with resp 2, data 0xFFFFFFFF -> rsp_* stable; stray calc_resp_in pulses ignored; release gives one transfer.
- Reset asserted during WAIT_RESP with 2 queued -> outputs 0 immediately, busy 0, no response emitted after deassertion.
